// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package acc_cpu_pkg;

    // Opcodes occupy the top nibble of every instruction word.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } cpu_state_t;

endpackage

// File: rtl/acc_cpu_param_if.sv
// Host-side bundle of the accumulator CPU: program load port, start strobe, status.
// Latency: wires only; timing is defined by the core.
// Backpressure: none; load and start are plain strobes, status is free-running.
// master = host (drives load_*/start), slave = CPU core (drives acc/pc/flags/out_*/busy/halted).
interface acc_cpu_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [4+DW-1:0]   load_data;
    logic              start;
    logic [DW-1:0]     acc;
    logic [AW-1:0]     pc;
    logic              zero;
    logic              carry;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              busy;
    logic              halted;

    modport master (
        output load_en, load_addr, load_data, start,
        input  acc, pc, zero, carry, out_data, out_valid, busy, halted
    );

    modport slave (
        input  load_en, load_addr, load_data, start,
        output acc, pc, zero, carry, out_data, out_valid, busy, halted
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the accumulator/flag update for one opcode.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
// Ports: acc_i/imm_i operands, op_i opcode, c_i current carry;
//        res_o/c_o/z_o results, wr_acc_o/wr_c_o say which registers the op updates.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] acc_i,
    input  logic [DW-1:0] imm_i,
    input  logic [3:0]    op_i,
    input  logic          c_i,
    output logic [DW-1:0] res_o,
    output logic          c_o,
    output logic          z_o,
    output logic          wr_acc_o,
    output logic          wr_c_o
);

    // One extra bit holds the carry out of ADD and the borrow out of SUB.
    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, acc_i} + {1'b0, imm_i};
    assign diff = {1'b0, acc_i} - {1'b0, imm_i};

    always_comb begin
        res_o    = acc_i;
        c_o      = c_i;
        wr_acc_o = 1'b0;
        wr_c_o   = 1'b0;
        case (op_i)
            OP_LDI: begin res_o = imm_i;          wr_acc_o = 1'b1; end
            OP_ADD: begin {c_o, res_o} = sum;     wr_acc_o = 1'b1; wr_c_o = 1'b1; end
            OP_SUB: begin {c_o, res_o} = diff;    wr_acc_o = 1'b1; wr_c_o = 1'b1; end
            OP_AND: begin res_o = acc_i & imm_i;  wr_acc_o = 1'b1; end
            OP_OR:  begin res_o = acc_i | imm_i;  wr_acc_o = 1'b1; end
            OP_XOR: begin res_o = acc_i ^ imm_i;  wr_acc_o = 1'b1; end
            OP_SHL: begin
                c_o      = acc_i[DW-1];
                res_o    = {acc_i[DW-2:0], 1'b0};
                wr_acc_o = 1'b1;
                wr_c_o   = 1'b1;
            end
            OP_SHR: begin
                c_o      = acc_i[0];
                res_o    = {1'b0, acc_i[DW-1:1]};
                wr_acc_o = 1'b1;
                wr_c_o   = 1'b1;
            end
            default: ;
        endcase
    end

    // Z follows the accumulator write enable: only ops that write acc touch Z.
    assign z_o = (res_o == '0);

endmodule

// File: rtl/acc_cpu_param.sv
// Accumulator CPU with host-loadable program memory, Z/C flags, jumps, OUT strobe and HALT.
// Latency: one instruction per cycle; results visible the cycle after the commit edge.
// Backpressure: none; load_en honoured only in IDLE, start only in IDLE/HALT.
// Ports: clk, rst_n (async active-low), bus (slave side of acc_cpu_param_if).
module acc_cpu_param
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    acc_cpu_param_if.slave bus
);

    localparam int IW    = 4 + DW;
    localparam int DEPTH = 1 << AW;

    logic [IW-1:0] mem_q [DEPTH];

    cpu_state_t    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_o, halted_o;

    logic [IW-1:0] instr;
    logic [3:0]    op;
    logic [DW-1:0] imm;
    logic          start_ok;

    logic [DW-1:0] alu_res;
    logic          alu_c, alu_z, alu_wr_acc, alu_wr_c;

    // Combinational fetch: the word at pc executes on the next edge.
    assign instr = mem_q[pc_q];
    assign op    = instr[IW-1:DW];
    assign imm   = instr[DW-1:0];

    // start restarts from IDLE or HALT alike; it is ignored while running.
    assign start_ok = bus.start && (state_q != RUN);

    acc_cpu_alu #(.DW(DW)) u_alu (
        .acc_i    (acc_q),
        .imm_i    (imm),
        .op_i     (op),
        .c_i      (c_q),
        .res_o    (alu_res),
        .c_o      (alu_c),
        .z_o      (alu_z),
        .wr_acc_o (alu_wr_acc),
        .wr_c_o   (alu_wr_c)
    );

    // Program memory is deliberately not reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (op == OP_HALT) state_d = HALT;
            HALT:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o   = 1'b0;
        halted_o = 1'b0;
        case (state_q)
            RUN:     busy_o   = 1'b1;
            HALT:    halted_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        pc_d        = pc_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (start_ok) begin
            pc_d  = '0;
            acc_d = '0;
            z_d   = 1'b0;
            c_d   = 1'b0;
        end else if (state_q == RUN) begin
            pc_d = pc_q + AW'(1);
            if (alu_wr_acc) begin
                acc_d = alu_res;
                z_d   = alu_z;
            end
            if (alu_wr_c) begin
                c_d = alu_c;
            end
            case (op)
                OP_JMP:  pc_d = imm[AW-1:0];
                OP_JZ:   if (z_q) pc_d = imm[AW-1:0];
                OP_JC:   if (c_q) pc_d = imm[AW-1:0];
                OP_OUT:  begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                end
                OP_HALT: pc_d = pc_q;   // pc keeps pointing at the HALT word
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.acc       = acc_q;
    assign bus.pc        = pc_q;
    assign bus.zero      = z_q;
    assign bus.carry     = c_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_o;
    assign bus.halted    = halted_o;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Self-checking bench for acc_cpu_param against an instruction-level reference model.
// Latency: model executes one instruction per clock, matching the architectural timing.
// Backpressure: none; the bench drives strobes directly.
module tb_acc_cpu_param;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int IW = 4 + DW;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic clk;
    logic rst_n;

    acc_cpu_param_if #(.DW(DW), .AW(AW)) bus ();

    acc_cpu_param #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural state as plain integers.
    int m_mem [16];
    int m_acc, m_pc, m_z, m_c, m_out, m_ov, m_state;

    int prog_q [$];
    int obs_out [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ins(int op, int imm);
        return op * 256 + imm;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".acc"},       32'(bus.acc),       m_acc);
        check({tag, ".pc"},        32'(bus.pc),        m_pc);
        check({tag, ".zero"},      32'(bus.zero),      m_z);
        check({tag, ".carry"},     32'(bus.carry),     m_c);
        check({tag, ".out_valid"}, 32'(bus.out_valid), m_ov);
        check({tag, ".out_data"},  32'(bus.out_data),  m_out);
        check({tag, ".busy"},      32'(bus.busy),      (m_state == S_RUN) ? 1 : 0);
        check({tag, ".halted"},    32'(bus.halted),    (m_state == S_HALT) ? 1 : 0);
    endtask

    function automatic void model_reset();
        m_acc = 0; m_pc = 0; m_z = 0; m_c = 0;
        m_out = 0; m_ov = 0; m_state = S_IDLE;
    endfunction

    // One instruction per call, written from the ISA description.
    function automatic void model_exec();
        int op, imm, s, nxt;
        m_ov = 0;
        if (m_state != S_RUN) return;
        op  = m_mem[m_pc] / 256;
        imm = m_mem[m_pc] % 256;
        nxt = (m_pc + 1) % 16;
        case (op)
            1:  m_acc = imm;
            2:  begin s = m_acc + imm; m_c = (s > 255) ? 1 : 0; m_acc = s % 256; end
            3:  begin s = m_acc - imm; m_c = (s < 0) ? 1 : 0; m_acc = (s + 256) % 256; end
            4:  m_acc = m_acc & imm;
            5:  m_acc = m_acc | imm;
            6:  m_acc = m_acc ^ imm;
            7:  begin m_c = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; end
            8:  begin m_c = m_acc % 2; m_acc = m_acc / 2; end
            9:  nxt = imm % 16;
            10: if (m_z != 0) nxt = imm % 16;
            11: if (m_c != 0) nxt = imm % 16;
            12: begin m_out = m_acc; m_ov = 1; end
            15: begin m_state = S_HALT; nxt = m_pc; end
            default: ;
        endcase
        if (op >= 1 && op <= 8) m_z = (m_acc == 0) ? 1 : 0;
        m_pc = nxt;
    endfunction

    // Asserts rst_n away from the clock edge so the clear is seen asynchronously.
    task automatic do_reset(string tag);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_prog();
        foreach (prog_q[i]) begin
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(i);
            bus.load_data = IW'(prog_q[i]);
            @(posedge clk); #1;
            if (m_state == S_IDLE) m_mem[i] = prog_q[i];
        end
        bus.load_en = 1'b0;
    endtask

    // Pulse start (optionally with a same-cycle write), then step model and DUT together.
    task automatic run(string tag, int ncyc, bit noise, bit wr, int waddr, int wdata);
        int hold;
        bus.start     = 1'b1;
        bus.load_en   = wr;
        bus.load_addr = AW'(waddr);
        bus.load_data = IW'(wdata);
        if (wr && m_state == S_IDLE) m_mem[waddr] = wdata;
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_ov = 0; m_state = S_RUN;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        check_all({tag, ".start"});
        obs_out.delete();
        hold = 0;
        for (int i = 0; i < ncyc && hold < 2; i++) begin
            if (noise) begin
                bus.load_en   = 1'($urandom_range(0, 1));
                bus.load_addr = AW'($urandom_range(0, 15));
                bus.load_data = IW'($urandom_range(0, 4095));
            end
            model_exec();
            @(posedge clk); #1;
            check_all(tag);
            if (bus.out_valid === 1'b1) obs_out.push_back(int'(bus.out_data));
            if (m_state == S_HALT) hold++;
        end
        bus.load_en = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        @(posedge clk); #1;
        do_reset("reset0");

        // Arithmetic: F0 + 20 wraps to 10 with carry.
        prog_q = '{ins(1, 'hF0), ins(2, 'h20), ins(12, 0), ins(15, 0)};
        load_prog();
        run("arith", 12, 1'b0, 1'b0, 0, 0);
        check("arith.pulses", 32'(obs_out.size()), 1);
        check("arith.out_data", 32'(bus.out_data), 'h10);
        check("arith.carry", 32'(bus.carry), 1);
        check("arith.pc", 32'(bus.pc), 3);
        check("arith.halted", 32'(bus.halted), 1);

        // Borrow / zero with a taken JZ.
        do_reset("reset1");
        prog_q = '{ins(1, 5), ins(3, 5), ins(10, 4), ins(15, 0),
                   ins(1, 1), ins(3, 2), ins(15, 0)};
        load_prog();
        run("borrow", 16, 1'b0, 1'b0, 0, 0);
        check("borrow.acc", 32'(bus.acc), 'hFF);
        check("borrow.carry", 32'(bus.carry), 1);
        check("borrow.zero", 32'(bus.zero), 0);
        check("borrow.pc", 32'(bus.pc), 6);

        // Countdown loop with load_en noise while running; HALT at the last address.
        do_reset("reset2");
        prog_q = '{ins(1, 3), ins(3, 1), ins(12, 0), ins(10, 15), ins(9, 1)};
        for (int i = 5; i < 15; i++) prog_q.push_back(ins(0, 0));
        prog_q.push_back(ins(15, 0));
        load_prog();
        run("loop", 60, 1'b1, 1'b0, 0, 0);
        check("loop.pulses", 32'(obs_out.size()), 3);
        if (obs_out.size() == 3) begin
            check("loop.out0", 32'(obs_out[0]), 2);
            check("loop.out1", 32'(obs_out[1]), 1);
            check("loop.out2", 32'(obs_out[2]), 0);
        end
        check("loop.pc", 32'(bus.pc), 15);

        // Reset mid-run, then rerun from retained memory.
        run("midrun", 4, 1'b0, 1'b0, 0, 0);
        do_reset("reset_midrun");
        run("retained", 60, 1'b0, 1'b0, 0, 0);
        check("retained.pulses", 32'(obs_out.size()), 3);

        // All-NOP memory: pc wraps 15 -> 0.
        do_reset("reset3");
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back(ins(0, 0));
        load_prog();
        run("wrap", 18, 1'b0, 1'b0, 0, 0);
        check("wrap.pc", 32'(bus.pc), 2);
        check("wrap.busy", 32'(bus.busy), 1);

        // Shifts, then restart from HALT.
        do_reset("reset4");
        prog_q = '{ins(1, 'h81), ins(7, 0), ins(8, 0), ins(15, 0)};
        load_prog();
        run("shift", 10, 1'b0, 1'b0, 0, 0);
        check("shift.acc", 32'(bus.acc), 1);
        check("shift.carry", 32'(bus.carry), 0);
        run("restart", 10, 1'b1, 1'b0, 0, 0);
        check("restart.acc", 32'(bus.acc), 1);

        // Write plus start in the same IDLE cycle executes the new word.
        do_reset("reset5");
        run("wrstart", 10, 1'b0, 1'b1, 0, ins(1, 'h5A));
        check("wrstart.acc", 32'(bus.acc), 'h5A);

        // Random programs against the model.
        for (int t = 0; t < 8; t++) begin
            do_reset("reset_rand");
            prog_q.delete();
            for (int i = 0; i < 16; i++)
                prog_q.push_back(ins($urandom_range(0, 15), $urandom_range(0, 255)));
            load_prog();
            run("rand", 40, 1'b1, 1'b0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
